// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - single-voice ADSR envelope generator with gain scaling
module adsr_envelope #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         SAMPLE_TICK,
   input  logic         KEY,
   input  logic [W-1:0] ATTACK,
   input  logic [W-1:0] DECAY,
   input  logic [W-1:0] SUSTAIN,
   input  logic [W-1:0] RLEASE,
   input  logic [W-1:0] GAIN,
   output logic [W-1:0] ENV_LEVEL,
   output logic         ENV_VALID,
   output logic [2:0]   ENV_STATE,
   output logic         ACTIVE,
   output logic [W-1:0] SCALED,
   output logic         SCALED_VALID
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   localparam logic [W-1:0] LMAX   = {W{1'b1}};
   localparam logic [W:0]   LMAX_X = {1'b0, {W{1'b1}}};

   state_t       state_q, state_d, eff_state;
   logic [W-1:0] level_q, level_d;
   logic         key_prev_q, key_prev_d;
   logic         valid_q, active_q, active_d;
   logic [W-1:0] scaled_q;
   logic         scaled_valid_q;
   logic [W:0]   sum_x, thr_x, level_x;

   // Tick-gated key edge detection, transition priority and per-state step arithmetic
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      key_prev_d = key_prev_q;
      eff_state  = state_q;
      level_x    = {1'b0, level_q};
      sum_x      = level_x + {1'b0, ATTACK};
      thr_x      = {1'b0, SUSTAIN} + {1'b0, DECAY};
      if (SAMPLE_TICK) begin
         key_prev_d = KEY;
         if (KEY && !key_prev_q) begin
            eff_state = ST_ATTACK;
         end else if (!KEY && key_prev_q &&
                      (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            eff_state = ST_RELEASE;
         end
         // The step of the state we land in is applied on this very tick
         case (eff_state)
            ST_ATTACK: begin
               if (sum_x >= LMAX_X || ATTACK == '0) begin
                  level_d = LMAX;
                  state_d = ST_DECAY;
               end else begin
                  level_d = sum_x[W-1:0];
                  state_d = ST_ATTACK;
               end
            end
            ST_DECAY: begin
               // Covers a level already under SUSTAIN (snap up) as well as the last step down
               if (DECAY == '0 || level_x <= thr_x) begin
                  level_d = SUSTAIN;
                  state_d = ST_SUSTAIN;
               end else begin
                  level_d = level_q - DECAY;
                  state_d = ST_DECAY;
               end
            end
            ST_SUSTAIN: begin
               level_d = SUSTAIN;
               state_d = ST_SUSTAIN;
            end
            ST_RELEASE: begin
               if (RLEASE == '0 || level_q <= RLEASE) begin
                  level_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  level_d = level_q - RLEASE;
                  state_d = ST_RELEASE;
               end
            end
            default: begin
               level_d = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
      active_d = (state_d != ST_IDLE);
   end

   // Envelope state register; a tick in cycle t shows up with ENV_VALID in cycle t+1
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         level_q    <= '0;
         key_prev_q <= 1'b0;
         valid_q    <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         key_prev_q <= key_prev_d;
         valid_q    <= SAMPLE_TICK;
         active_q   <= active_d;
      end
   end

   // Gain stage: multiply the fresh level by GAIN, keep the upper W bits
   always_ff @(posedge CLK) begin
      if (RESET) begin
         scaled_q       <= '0;
         scaled_valid_q <= 1'b0;
      end else begin
         scaled_valid_q <= valid_q;
         if (valid_q) begin
            scaled_q <= W'(({{W{1'b0}}, level_q} * {{W{1'b0}}, GAIN}) >> W);
         end
      end
   end

   assign ENV_LEVEL    = level_q;
   assign ENV_VALID    = valid_q;
   assign ENV_STATE    = state_q;
   assign ACTIVE       = active_q;
   assign SCALED       = scaled_q;
   assign SCALED_VALID = scaled_valid_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - scoreboard bench for adsr_envelope
module tb_adsr_envelope;

   logic        CLK = 1'b0;
   logic        RESET, SAMPLE_TICK, KEY;
   logic [15:0] ATTACK, DECAY, SUSTAIN, RLEASE, GAIN;
   logic [15:0] ENV_LEVEL, SCALED;
   logic        ENV_VALID, ACTIVE, SCALED_VALID;
   logic [2:0]  ENV_STATE;

   typedef struct {
      logic [2:0]  st;
      logic [15:0] lv;
   } env_exp_t;

   env_exp_t    env_q[$];
   logic [15:0] scl_q[$];
   int          total  = 0;
   int          passed = 0;
   logic        prev_ev = 1'b0;

   adsr_envelope #(.W(16)) dut (
      .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .KEY(KEY),
      .ATTACK(ATTACK), .DECAY(DECAY), .SUSTAIN(SUSTAIN), .RLEASE(RLEASE), .GAIN(GAIN),
      .ENV_LEVEL(ENV_LEVEL), .ENV_VALID(ENV_VALID), .ENV_STATE(ENV_STATE), .ACTIVE(ACTIVE),
      .SCALED(SCALED), .SCALED_VALID(SCALED_VALID)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      else passed++;
   endtask

   // Called just after a posedge: drive one tick, queue its expected outputs
   task automatic tick(input logic key, input logic [2:0] st, input logic [15:0] lv,
                       input logic [15:0] sc);
      env_exp_t e;
      KEY = key;
      SAMPLE_TICK = 1'b1;
      e.st = st;
      e.lv = lv;
      env_q.push_back(e);
      scl_q.push_back(sc);
      @(posedge CLK); #1;
      SAMPLE_TICK = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a valid output
   always @(negedge CLK) begin
      env_exp_t e;
      logic [15:0] s;
      if (ENV_VALID) begin
         if (env_q.size() == 0) chk("env_valid_unexpected", 32'd1, 32'd0);
         else begin
            e = env_q.pop_front();
            chk("env_state", {29'd0, ENV_STATE}, {29'd0, e.st});
            chk("env_level", {16'd0, ENV_LEVEL}, {16'd0, e.lv});
            chk("active", {31'd0, ACTIVE}, {31'd0, (e.st != 3'd0)});
         end
      end
      if (SCALED_VALID) begin
         if (scl_q.size() == 0) chk("scaled_valid_unexpected", 32'd1, 32'd0);
         else begin
            s = scl_q.pop_front();
            chk("scaled", {16'd0, SCALED}, {16'd0, s});
         end
      end
      if (ENV_VALID || SCALED_VALID || prev_ev)
         chk("scaled_valid_lag", {31'd0, SCALED_VALID}, {31'd0, prev_ev});
      prev_ev = ENV_VALID;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; SAMPLE_TICK = 1'b0; KEY = 1'b0;
      ATTACK = 16'h4000; DECAY = 16'h2000; SUSTAIN = 16'h8000; RLEASE = 16'h3000;
      GAIN = 16'hFFFF;
      idle(3);
      RESET = 1'b0;
      chk("rst_state", {29'd0, ENV_STATE}, 32'd0);
      chk("rst_level", {16'd0, ENV_LEVEL}, 32'd0);
      chk("rst_active", {31'd0, ACTIVE}, 32'd0);
      chk("rst_scaled", {16'd0, SCALED}, 32'd0);
      chk("rst_valids", {30'd0, ENV_VALID, SCALED_VALID}, 32'd0);
      idle(2);

      // Attack through decay into sustain, ticks spaced 3 cycles apart
      tick(1'b0, 3'd0, 16'h0000, 16'h0000); idle(2);
      tick(1'b1, 3'd1, 16'h4000, 16'h3FFF); idle(2);
      tick(1'b1, 3'd1, 16'h8000, 16'h7FFF); idle(2);
      tick(1'b1, 3'd1, 16'hC000, 16'hBFFF); idle(2);
      tick(1'b1, 3'd2, 16'hFFFF, 16'hFFFE); idle(2);
      tick(1'b1, 3'd2, 16'hDFFF, 16'hDFFE); idle(2);
      tick(1'b1, 3'd2, 16'hBFFF, 16'hBFFE); idle(2);
      tick(1'b1, 3'd2, 16'h9FFF, 16'h9FFE); idle(2);
      tick(1'b1, 3'd3, 16'h8000, 16'h7FFF); idle(2);
      tick(1'b1, 3'd3, 16'h8000, 16'h7FFF); idle(2);

      // No tick for 50 cycles: SUSTAIN change must not show until the next tick
      SUSTAIN = 16'h9000;
      idle(50);
      chk("gate_level", {16'd0, ENV_LEVEL}, 32'h8000);
      chk("gate_state", {29'd0, ENV_STATE}, 32'd3);
      tick(1'b1, 3'd3, 16'h9000, 16'h8FFF); idle(2);
      SUSTAIN = 16'h8000;
      tick(1'b1, 3'd3, 16'h8000, 16'h7FFF); idle(2);

      // Release, then retrigger at 0x2000 with half gain
      tick(1'b0, 3'd4, 16'h5000, 16'h4FFF); idle(2);
      tick(1'b0, 3'd4, 16'h2000, 16'h1FFF); idle(2);
      ATTACK = 16'h1000;
      GAIN   = 16'h8000;
      tick(1'b1, 3'd1, 16'h3000, 16'h1800); idle(2);
      GAIN   = 16'hFFFF;
      tick(1'b0, 3'd0, 16'h0000, 16'h0000); idle(2);

      // Short KEY glitch between ticks is ignored
      KEY = 1'b1; idle(3); KEY = 1'b0; idle(1);
      tick(1'b0, 3'd0, 16'h0000, 16'h0000); idle(2);

      // Zero-rate shortcuts
      ATTACK = 16'h0000; DECAY = 16'h0000; SUSTAIN = 16'h1234;
      tick(1'b1, 3'd2, 16'hFFFF, 16'hFFFE); idle(2);
      tick(1'b1, 3'd3, 16'h1234, 16'h1233); idle(2);
      RLEASE = 16'h0000;
      tick(1'b0, 3'd0, 16'h0000, 16'h0000); idle(2);

      // Back-to-back ticks
      ATTACK = 16'h4000; DECAY = 16'h2000; SUSTAIN = 16'h8000; RLEASE = 16'h5000;
      tick(1'b1, 3'd1, 16'h4000, 16'h3FFF);
      tick(1'b1, 3'd1, 16'h8000, 16'h7FFF);
      tick(1'b1, 3'd1, 16'hC000, 16'hBFFF);
      tick(1'b1, 3'd2, 16'hFFFF, 16'hFFFE);
      tick(1'b1, 3'd2, 16'hDFFF, 16'hDFFE);
      tick(1'b1, 3'd2, 16'hBFFF, 16'hBFFE);
      tick(1'b1, 3'd2, 16'h9FFF, 16'h9FFE);
      tick(1'b1, 3'd3, 16'h8000, 16'h7FFF);
      tick(1'b0, 3'd4, 16'h3000, 16'h2FFF);
      idle(4);

      // Reset mid-RELEASE at 0x3000, together with a tick and KEY high
      RESET = 1'b1; SAMPLE_TICK = 1'b1; KEY = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0; SAMPLE_TICK = 1'b0; KEY = 1'b0;
      chk("rst2_state", {29'd0, ENV_STATE}, 32'd0);
      chk("rst2_level", {16'd0, ENV_LEVEL}, 32'd0);
      chk("rst2_active", {31'd0, ACTIVE}, 32'd0);
      chk("rst2_scaled", {16'd0, SCALED}, 32'd0);
      chk("rst2_valids", {30'd0, ENV_VALID, SCALED_VALID}, 32'd0);
      idle(3);
      chk("rst2_valids_later", {30'd0, ENV_VALID, SCALED_VALID}, 32'd0);

      // key_prev was cleared, so KEY high is a fresh press
      tick(1'b1, 3'd1, 16'h4000, 16'h3FFF);
      idle(5);
      chk("env_queue_drained", env_q.size(), 32'd0);
      chk("scaled_queue_drained", scl_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
